// File: rtl/demod_frame_ctrl.sv
// -----------------------------------------------------------------------------
// demod_frame_ctrl
//
// Frame controller for a 2-bit-per-symbol demodulator. It generates the symbol
// clock strobe and captures one symbol per symbol period. It hunts for a
// 4-symbol sync word, then reads a 4-symbol payload length. It then assembles
// payload symbols into bytes, MSB first, and hands them to a valid/ready sink.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   enable       in   run control; low returns the controller to IDLE
//   sym_strobe   out  one-cycle pulse at the end of each symbol period
//   sym_in[1:0]  in   demodulated symbol, stable from the cycle after sym_strobe
//   byte_data    out  assembled payload byte
//   byte_valid   out  byte_data valid, held until accepted
//   byte_ready   in   sink accepts when byte_valid and byte_ready are both high
//   frame_active out  high while reading the length and the payload
//   frame_done   out  one-cycle pulse after the last payload byte
//   overrun      out  sticky: a payload byte was dropped, cleared only by reset
// -----------------------------------------------------------------------------
module demod_frame_ctrl #(
    parameter int         SYM_LEN   = 128,
    parameter logic [7:0] SYNC_WORD = 8'hB4,
    parameter int         MAX_LEN   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       sym_strobe,
    input  logic [1:0] sym_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_active,
    output logic       frame_done,
    output logic       overrun
);

    localparam int CNT_W     = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
    localparam int LEN_W_MIN = $clog2(MAX_LEN + 1);
    // The length field is 8 bits wide, so the counters never need fewer bits.
    localparam int LEN_W     = (LEN_W_MIN > 8) ? LEN_W_MIN : 8;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SYM_LEN - 1);
    localparam logic [31:0]      MAX_LEN_U = 32'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        LEN,
        PAYLOAD,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Symbol timing
    logic [CNT_W-1:0] cnt;
    logic             strobe_d;

    // Symbol history: the three most recent captured symbols
    logic [5:0]       sreg;
    logic [1:0]       sym_idx;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] byte_cnt;

    logic       capture;
    logic [7:0] sreg_shift;
    logic       last_sym;
    logic       len_bad;
    logic       byte_done;
    logic       frame_end;
    logic       accept;
    logic       state_change;

    assign sym_strobe = (cnt == CNT_LAST);

    // The counter wraps to 0 right after a strobe, so a delayed strobe marks
    // the cnt==0 cycle in which the demodulator output has settled.
    assign capture = strobe_d && (cnt == '0) && (state != IDLE) && enable;

    // Value the 4-symbol window holds once the current symbol is shifted in.
    assign sreg_shift = {sreg, sym_in};
    assign last_sym   = (sym_idx == 2'd3);
    assign len_bad    = (sreg_shift == 8'd0) || ({24'd0, sreg_shift} > MAX_LEN_U);
    assign byte_done  = capture && (state == PAYLOAD) && last_sym;
    assign frame_end  = byte_done && (byte_cnt == (len - LEN_W'(1)));
    assign accept     = byte_valid && byte_ready;

    assign state_change = (state_nxt != state);

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        frame_active = 1'b0;
        frame_done   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = HUNT;
                end
            end
            HUNT: begin
                if (capture && (sreg_shift == SYNC_WORD)) begin
                    state_nxt = LEN;
                end
            end
            LEN: begin
                frame_active = 1'b1;
                if (capture && last_sym) begin
                    state_nxt = len_bad ? HUNT : PAYLOAD;
                end
            end
            PAYLOAD: begin
                frame_active = 1'b1;
                if (frame_end) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = HUNT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Dropping enable wins over every other transition.
        if (!enable) begin
            state_nxt = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Control registers: state, symbol timing, symbol index, byte count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            strobe_d <= 1'b0;
            sym_idx  <= 2'd0;
            byte_cnt <= '0;
        end else begin
            state    <= state_nxt;
            strobe_d <= sym_strobe;

            // Counter sits at 0 in IDLE so timing restarts cleanly on HUNT entry.
            if ((state == IDLE) || !enable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if ((state == IDLE) || state_change) begin
                sym_idx <= 2'd0;
            end else if (capture && ((state == LEN) || (state == PAYLOAD))) begin
                sym_idx <= sym_idx + 2'd1;
            end

            // Dropped bytes still advance the count so the frame ends on time.
            if (state != PAYLOAD) begin
                byte_cnt <= '0;
            end else if (byte_done) begin
                byte_cnt <= byte_cnt + LEN_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Symbol history and frame length
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // Clearing on every state entry means a sync match always needs four
        // fresh symbols after HUNT is (re)entered.
        if ((state == IDLE) || state_change) begin
            sreg <= '0;
        end else if (capture) begin
            sreg <= sreg_shift[5:0];
        end

        if (capture && (state == LEN) && last_sym) begin
            len <= LEN_W'(sreg_shift);
        end
    end

    // ------------------------------------------------------------------
    // Output byte register with valid/ready handshake and overrun detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (!enable || (state == IDLE)) begin
            // Pending byte is dropped; overrun history is kept.
            byte_valid <= 1'b0;
        end else if (byte_done) begin
            // The slot is free if empty or being accepted in this same cycle.
            if (!byte_valid || byte_ready) begin
                byte_data  <= sreg_shift;
                byte_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (accept) begin
            byte_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demod_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demod_frame_ctrl
//
// Directed bench for demod_frame_ctrl. Expected payload bytes are queued when
// the stimulus is issued. A monitor pops and compares a byte on every
// byte_valid/byte_ready handshake. Timing, flag and reset behaviour are checked
// directly against hand-computed values.
// -----------------------------------------------------------------------------
module tb_demod_frame_ctrl;

    localparam int SYM_LEN = 128;
    localparam int MAX_LEN = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] sym_in = 2'd0;
    logic       byte_ready = 1'b0;
    logic       sym_strobe;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_active;
    logic       frame_done;
    logic       overrun;

    demod_frame_ctrl #(
        .SYM_LEN  (SYM_LEN),
        .SYNC_WORD(8'hB4),
        .MAX_LEN  (MAX_LEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sym_strobe  (sym_strobe),
        .sym_in      (sym_in),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .frame_active(frame_active),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    int         valid_cycles = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    // Scoreboard monitor: samples mid-cycle, compares on each handshake.
    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (byte_valid) valid_cycles++;
        if (reset && byte_valid && byte_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_byte got=%02h expected=none", byte_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (byte_data !== mon_exp) begin
                    failures++;
                    $display("FAIL byte_data got=%02h expected=%02h", byte_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0b expected=%0b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%02h expected=%02h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_strobe"}, sym_strobe, 1'b0);
        chk8({tag, "_byte_data"}, byte_data, 8'h00);
        chk1({tag, "_byte_valid"}, byte_valid, 1'b0);
        chk1({tag, "_frame_active"}, frame_active, 1'b0);
        chk1({tag, "_frame_done"}, frame_done, 1'b0);
        chk1({tag, "_overrun"}, overrun, 1'b0);
    endtask

    // Wait for a strobe, present the symbol in the following (capture) cycle,
    // optionally pulsing byte_ready in that same cycle. Returns just after the
    // capture edge.
    task automatic send_sym(input logic [1:0] s, input bit pulse_rdy);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 2 * SYM_LEN + 8; n++) begin
            @(negedge clk);
            if (sym_strobe) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL strobe_wait got=none expected=strobe");
        end
        @(posedge clk);
        #1;
        sym_in = s;
        if (pulse_rdy) byte_ready = 1'b1;
        @(posedge clk);
        #1;
        if (pulse_rdy) byte_ready = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_sym(b[7:6], 1'b0);
        send_sym(b[5:4], 1'b0);
        send_sym(b[3:2], 1'b0);
        send_sym(b[1:0], 1'b0);
    endtask

    task automatic send_header(input logic [7:0] len_field);
        send_byte(8'hB4);
        send_byte(len_field);
    endtask

    task automatic handshake_once();
        byte_ready = 1'b1;
        @(posedge clk);
        #1;
        byte_ready = 1'b0;
    endtask

    int k;
    int d0;
    int v0;
    int nstb;

    initial begin
        // Reset state
        #1;
        chk_reset_vals("reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk1("idle_no_strobe", sym_strobe, 1'b0);

        // Strobe timing: first strobe 128 edges after enable, then every 128
        enable = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!sym_strobe && k < 400);
        chki("first_strobe_delay", k, SYM_LEN);
        @(posedge clk);
        #1;
        chk1("strobe_width", sym_strobe, 1'b0);
        k = 1;
        while (!sym_strobe && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        chki("strobe_period", k, SYM_LEN);

        // Good frame, L=2, sink always ready
        byte_ready = 1'b1;
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'hE4);
        d0 = done_cnt;
        send_header(8'h02);
        chk1("good_frame_active", frame_active, 1'b1);
        send_sym(2'd0, 1'b0);
        send_sym(2'd1, 1'b0);
        send_sym(2'd2, 1'b0);
        send_sym(2'd3, 1'b0);
        send_sym(2'd3, 1'b0);
        send_sym(2'd2, 1'b0);
        send_sym(2'd1, 1'b0);
        send_sym(2'd0, 1'b0);
        chk1("good_frame_done", frame_done, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk1("good_frame_active_after", frame_active, 1'b0);
        chki("good_done_pulses", done_cnt - d0, 1);
        chki("good_queue_drained", exp_q.size(), 0);

        // Bad lengths: L=0, then L=33
        v0 = valid_cycles;
        d0 = done_cnt;
        send_header(8'h00);
        chk1("len0_inactive", frame_active, 1'b0);
        send_header(8'h21);
        chk1("len33_inactive", frame_active, 1'b0);
        chki("badlen_no_valid", valid_cycles - v0, 0);
        chki("badlen_no_done", done_cnt - d0, 0);

        // Backpressure: L=3, sink never ready during the frame
        byte_ready = 1'b0;
        d0 = done_cnt;
        send_header(8'h03);
        send_byte(8'h1B);
        chk1("bp_first_valid", byte_valid, 1'b1);
        chk1("bp_no_overrun_yet", overrun, 1'b0);
        send_byte(8'hE4);
        chk1("bp_overrun_set", overrun, 1'b1);
        chk8("bp_data_kept", byte_data, 8'h1B);
        send_byte(8'h5A);
        chk1("bp_frame_done", frame_done, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk1("bp_valid_survives", byte_valid, 1'b1);
        chk8("bp_data_final", byte_data, 8'h1B);
        chki("bp_done_pulses", done_cnt - d0, 1);
        exp_q.push_back(8'h1B);
        handshake_once();
        chk1("bp_valid_cleared", byte_valid, 1'b0);
        chk1("bp_overrun_sticky", overrun, 1'b1);

        // Clear the sticky flag with a reset pulse
        #3;
        reset = 1'b0;
        #1;
        chk1("reset_clears_overrun", overrun, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Handshake in the same cycle the second byte completes
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'hE4);
        send_header(8'h02);
        send_byte(8'h1B);
        chk1("sim_first_valid", byte_valid, 1'b1);
        send_sym(2'd3, 1'b0);
        send_sym(2'd2, 1'b0);
        send_sym(2'd1, 1'b0);
        send_sym(2'd0, 1'b1);
        chk1("sim_valid_held", byte_valid, 1'b1);
        chk8("sim_second_loaded", byte_data, 8'hE4);
        chk1("sim_no_overrun", overrun, 1'b0);
        handshake_once();
        chki("sim_queue_drained", exp_q.size(), 0);

        // Enable dropped in PAYLOAD with a byte pending
        send_header(8'h02);
        send_byte(8'h1B);
        chk1("abort_pending", byte_valid, 1'b1);
        send_sym(2'd0, 1'b0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk1("abort_valid_cleared", byte_valid, 1'b0);
        chk1("abort_inactive", frame_active, 1'b0);
        nstb = 0;
        repeat (2 * SYM_LEN) begin
            @(negedge clk);
            if (sym_strobe) nstb++;
        end
        chki("abort_no_strobes", nstb, 0);
        enable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk1("abort_byte_dropped", byte_valid, 1'b0);

        // Asynchronous reset in the middle of a frame
        send_header(8'h03);
        send_byte(8'h1B);
        send_byte(8'hE4);
        chk1("mid_overrun", overrun, 1'b1);
        chk1("mid_active", frame_active, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        chki("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demod_frame_ctrl.md
DEMOD_FRAME_CTRL -- requirements
Module: demod_frame_ctrl

Interface
REQ-001 SHALL have parameter SYM_LEN, default 128, clk cycles per symbol (minimum 4).
REQ-002 SHALL have parameter SYNC_WORD, default 8'hB4, 4-symbol sync pattern, MSB symbol first.
REQ-003 SHALL have parameter MAX_LEN, default 32, largest legal payload length in bytes.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  run control; low forces IDLE.
REQ-007 sym_strobe  output  1  one-cycle symbol-boundary pulse, drives the demodulator symbol clock.
REQ-008 sym_in  input  2  demodulated symbol, stable from the cycle after sym_strobe.
REQ-009 byte_data  output  8  assembled payload byte.
REQ-010 byte_valid  output  1  byte_data valid; held until accepted.
REQ-011 byte_ready  input  1  sink accepts byte when byte_valid and byte_ready are both high.
REQ-012 frame_active  output  1  high in LEN and PAYLOAD states.
REQ-013 frame_done  output  1  one-cycle pulse at end of frame.
REQ-014 overrun  output  1  sticky flag, payload byte lost.

Function
REQ-015 Symbol counter cnt SHALL run 0..SYM_LEN-1 while enable high, wrap to 0; sym_strobe high exactly when cnt==SYM_LEN-1.
REQ-016 Symbol capture SHALL occur on the cycle with cnt==0 following a strobe; sym_in sampled only then.
REQ-017 Byte assembly SHALL be MSB first: first captured symbol -> bits[7:6], fourth -> bits[1:0].
REQ-018 FSM states SHALL be IDLE, HUNT, LEN, PAYLOAD, DONE.
REQ-019 IDLE: cnt, symbol shift register, symbol index and byte count held at 0; enable high -> HUNT next cycle.
REQ-020 HUNT: 8-bit shift register shifts in each captured symbol at LSB end; cleared on HUNT entry, so match needs 4 fresh symbols.
REQ-021 HUNT: shift register == SYNC_WORD after a capture -> LEN, symbol index reset to 0.
REQ-022 LEN: next 4 symbols form length L; L==0 or L>MAX_LEN -> HUNT, no output; else -> PAYLOAD.
REQ-023 PAYLOAD: each 4-symbol byte loaded into byte_data with byte_valid set the cycle after the fourth capture.
REQ-024 byte_valid SHALL clear on the cycle after handshake unless a new byte is loaded that same cycle.
REQ-025 New byte completes while byte_valid high and byte_ready low: new byte discarded, byte_data unchanged, overrun set.
REQ-026 New byte completes on the same cycle byte_ready accepts the old one: new byte loaded, byte_valid stays high, no overrun.
REQ-027 Discarded bytes SHALL still count toward L.
REQ-028 After the L-th byte is assembled -> DONE for one cycle; frame_done high that cycle; then HUNT.
REQ-029 A pending byte_valid SHALL survive DONE/HUNT until accepted.
REQ-030 enable low in any state -> IDLE next cycle; byte_valid cleared, pending byte dropped, overrun retained.
REQ-031 Length and byte counters SHALL be wide enough for MAX_LEN with no wrap.

Reset
REQ-032 reset low SHALL asynchronously force IDLE, cnt=0, sym_strobe=0, byte_data=8'h00, byte_valid=0, frame_active=0, frame_done=0, overrun=0.
REQ-033 overrun SHALL clear only on reset.
REQ-034 Reset released mid-symbol SHALL restart timing at cnt=0; first strobe SYM_LEN-1 cycles after enable reaches HUNT.

Verification
REQ-035 Strobe timing: enable high, SYM_LEN=128 -> sym_strobe pulses every 128 cycles, width 1.
REQ-036 Good frame: symbols 2,3,1,0 (sync B4), 0,0,0,2 (L=2), 0,1,2,3, 3,2,1,0, byte_ready=1 -> bytes 8'h1B, 8'hE4, then frame_done pulse; frame_active low after.
REQ-037 Bad length: sync then L=0 and sync then L=33 -> no byte_valid, FSM back in HUNT.
REQ-038 Backpressure: L=3, byte_ready low throughout -> byte_data = first byte, overrun=1, frame_done still after third byte.
REQ-039 Simultaneous: byte_ready pulses on the cycle the second byte completes -> first accepted, second valid, overrun=0.
REQ-040 Mid-frame abort: enable low during PAYLOAD -> IDLE, byte_valid=0; async reset mid-frame -> all outputs at reset values immediately.
